rob_recovery_walker: RTL and testbench

- Parametrised successor to the fixed 2-wide commit/recovery path.
- Keeps a per-ROB-entry shadow of rename metadata: destination ARF, previous PRF, has-destination flag and store flag.
- On commit, drives N-wide PRF recycle and store-commit outputs.
- On branch misprediction or full flush, walks the ROB from youngest to oldest, RECOVERY_WIDTH entries per cycle, restoring the speculative map and flushing store-buffer entries. Sits beside the ROB and feeds the rename/dispatch stage and the store buffer.

---
 rtl/rob_recovery_walker.sv | 184 ++++++++++++++++++
 tb/tb_rob_recovery_walker.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_recovery_walker.sv
// Per-entry rename shadow beside the ROB: N-wide commit recycle and
// youngest-first recovery walk on branch miss or full flush.
module rob_recovery_walker #(
  parameter int unsigned WIDTH          = 2,
  parameter int unsigned RECOVERY_WIDTH = 2,
  parameter int unsigned ROB_DEPTH      = 32,
  parameter int unsigned PRF_W          = 6,
  parameter int unsigned ARF_W          = 5,
  parameter int unsigned TAG_W          = $clog2(ROB_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                alloc_valid,
  input  logic [WIDTH*ARF_W-1:0]          alloc_arf,
  input  logic [WIDTH*PRF_W-1:0]          alloc_old_prf,
  input  logic [WIDTH-1:0]                alloc_has_dst,
  input  logic [WIDTH-1:0]                alloc_is_store,
  output logic                            alloc_ready,
  output logic [TAG_W-1:0]                alloc_tag,
  input  logic [WIDTH-1:0]                commit_valid,
  output logic [WIDTH*PRF_W-1:0]          recycle_prf,
  output logic [WIDTH-1:0]                recycle_valid,
  output logic [WIDTH-1:0]                store_commit_valid,
  input  logic                            flush_valid,
  input  logic [TAG_W-1:0]                flush_tag,
  input  logic                            flush_all,
  output logic [RECOVERY_WIDTH*ARF_W-1:0] rcv_arf,
  output logic [RECOVERY_WIDTH*PRF_W-1:0] rcv_old_prf,
  output logic [RECOVERY_WIDTH-1:0]       rcv_map_valid,
  output logic [RECOVERY_WIDTH-1:0]       rcv_store_flush,
  output logic                            rcv_busy,
  output logic                            rcv_done,
  output logic [TAG_W:0]                  occupancy
);

  localparam int unsigned CNT_W = TAG_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

  state_t                 r_state, w_state_next;
  logic [TAG_W-1:0]       r_head, r_tail, r_walkptr;
  logic [CNT_W-1:0]       r_occ, r_remaining;
  logic                   r_walk_all;
  logic [ARF_W-1:0]       r_arf     [ROB_DEPTH];
  logic [PRF_W-1:0]       r_old_prf [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]   r_has_dst, r_is_store;
  logic [WIDTH*PRF_W-1:0] r_recycle_prf;
  logic [WIDTH-1:0]       r_recycle_valid, r_store_commit_valid;

  logic                   w_flush_any, w_alloc_ready, w_retarget;
  logic [WIDTH-1:0]       w_commit_v;
  logic [CNT_W-1:0]       w_alloc_cnt, w_commit_cnt, w_walk_n, w_occ_next;
  logic [CNT_W-1:0]       w_rem_idle, w_rem_walk_next;
  logic [TAG_W-1:0]       w_target, w_dist_new, w_dist_tgt;

  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(WIDTH); i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Commits are frozen while a full flush is being applied.
  assign w_flush_any   = flush_valid | flush_all;
  assign w_alloc_ready = (r_state == S_IDLE) && !w_flush_any &&
                         ((CNT_W'(ROB_DEPTH) - r_occ) >= CNT_W'(WIDTH));
  assign w_alloc_cnt   = w_alloc_ready ? popcnt(alloc_valid) : '0;
  assign w_commit_v    = (flush_all || (r_walk_all && r_state != S_IDLE)) ? '0 : commit_valid;
  assign w_commit_cnt  = popcnt(w_commit_v);
  assign w_occ_next    = r_occ + w_alloc_cnt - w_commit_cnt - w_walk_n;

  // Target is the surviving entry just older than the last one to walk.
  assign w_target   = r_walkptr - r_remaining[TAG_W-1:0];
  assign w_dist_new = flush_tag - r_head;
  assign w_dist_tgt = w_target - r_head;
  assign w_retarget = flush_valid && !r_walk_all && (w_dist_new < w_dist_tgt);

  always_comb begin
    w_walk_n = '0;
    if (r_state == S_WALK)
      w_walk_n = (r_remaining < CNT_W'(RECOVERY_WIDTH)) ? r_remaining : CNT_W'(RECOVERY_WIDTH);
  end

  always_comb begin
    w_rem_idle      = flush_all ? r_occ : CNT_W'(r_tail - flush_tag - TAG_W'(1));
    w_rem_walk_next = r_remaining - w_walk_n;
    if (flush_all)       w_rem_walk_next = w_occ_next;
    else if (w_retarget) w_rem_walk_next = CNT_W'(r_walkptr - flush_tag) - w_walk_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_flush_any) w_state_next = (w_rem_idle == '0) ? S_DONE : S_WALK;
      S_WALK: if (w_rem_walk_next == '0) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rcv_arf         = '0;
    rcv_old_prf     = '0;
    rcv_map_valid   = '0;
    rcv_store_flush = '0;
    rcv_busy        = (r_state != S_IDLE);
    rcv_done        = (r_state == S_DONE);
    if (r_state == S_WALK) begin
      for (int j = 0; j < int'(RECOVERY_WIDTH); j++) begin
        if (CNT_W'(j) < w_walk_n) begin
          rcv_arf[j*ARF_W +: ARF_W]     = r_arf[r_walkptr - TAG_W'(j)];
          rcv_old_prf[j*PRF_W +: PRF_W] = r_old_prf[r_walkptr - TAG_W'(j)];
          rcv_map_valid[j]              = r_has_dst[r_walkptr - TAG_W'(j)];
          rcv_store_flush[j]            = r_is_store[r_walkptr - TAG_W'(j)];
        end
      end
    end
  end

  // Pointers, occupancy, walk bookkeeping and registered commit outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head               <= '0;
      r_tail               <= '0;
      r_occ                <= '0;
      r_walkptr            <= '0;
      r_remaining          <= '0;
      r_walk_all           <= 1'b0;
      r_recycle_prf        <= '0;
      r_recycle_valid      <= '0;
      r_store_commit_valid <= '0;
    end else begin
      r_head <= r_head + TAG_W'(w_commit_cnt);
      r_tail <= r_tail + TAG_W'(w_alloc_cnt) - TAG_W'(w_walk_n);
      r_occ  <= w_occ_next;
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_recycle_valid[i]             <= w_commit_v[i] & r_has_dst[r_head + TAG_W'(i)];
        r_store_commit_valid[i]        <= w_commit_v[i] & r_is_store[r_head + TAG_W'(i)];
        r_recycle_prf[i*PRF_W +: PRF_W] <= w_commit_v[i] ? r_old_prf[r_head + TAG_W'(i)] : '0;
      end
      case (r_state)
        S_IDLE: if (w_flush_any) begin
          r_walkptr   <= r_tail - TAG_W'(1);
          r_remaining <= w_rem_idle;
          r_walk_all  <= flush_all;
        end
        S_WALK: begin
          r_walkptr   <= r_walkptr - TAG_W'(w_walk_n);
          r_remaining <= w_rem_walk_next;
          if (flush_all) r_walk_all <= 1'b1;
        end
        default: begin
          r_remaining <= '0;
          r_walk_all  <= 1'b0;
        end
      endcase
    end
  end

  // Shadow table; contents are don't-care until allocated.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (w_alloc_ready && alloc_valid[i]) begin
        r_arf[r_tail + TAG_W'(i)]      <= alloc_arf[i*ARF_W +: ARF_W];
        r_old_prf[r_tail + TAG_W'(i)]  <= alloc_old_prf[i*PRF_W +: PRF_W];
        r_has_dst[r_tail + TAG_W'(i)]  <= alloc_has_dst[i];
        r_is_store[r_tail + TAG_W'(i)] <= alloc_is_store[i];
      end
    end
  end

  assign alloc_ready        = w_alloc_ready;
  assign alloc_tag          = r_tail;
  assign occupancy          = r_occ;
  assign recycle_prf        = r_recycle_prf;
  assign recycle_valid      = r_recycle_valid;
  assign store_commit_valid = r_store_commit_valid;

endmodule

// File: tb/tb_rob_recovery_walker.sv
// Scoreboard bench for rob_recovery_walker (WIDTH=2, RECOVERY_WIDTH=2, ROB_DEPTH=8).
module tb_rob_recovery_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  alloc_valid = '0, alloc_has_dst = '0, alloc_is_store = '0;
  logic [9:0]  alloc_arf = '0;
  logic [11:0] alloc_old_prf = '0;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic [1:0]  commit_valid = '0;
  logic [11:0] recycle_prf;
  logic [1:0]  recycle_valid, store_commit_valid;
  logic        flush_valid = 1'b0, flush_all = 1'b0;
  logic [2:0]  flush_tag = '0;
  logic [9:0]  rcv_arf;
  logic [11:0] rcv_old_prf;
  logic [1:0]  rcv_map_valid, rcv_store_flush;
  logic        rcv_busy, rcv_done;
  logic [3:0]  occupancy;

  rob_recovery_walker #(.WIDTH(2), .RECOVERY_WIDTH(2), .ROB_DEPTH(8), .PRF_W(6), .ARF_W(5)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_arf(alloc_arf), .alloc_old_prf(alloc_old_prf),
    .alloc_has_dst(alloc_has_dst), .alloc_is_store(alloc_is_store),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .commit_valid(commit_valid), .recycle_prf(recycle_prf), .recycle_valid(recycle_valid),
    .store_commit_valid(store_commit_valid),
    .flush_valid(flush_valid), .flush_tag(flush_tag), .flush_all(flush_all),
    .rcv_arf(rcv_arf), .rcv_old_prf(rcv_old_prf), .rcv_map_valid(rcv_map_valid),
    .rcv_store_flush(rcv_store_flush), .rcv_busy(rcv_busy), .rcv_done(rcv_done),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  rv;
    logic [1:0]  sv;
    logic [11:0] prf;
    logic [11:0] mask;
  } rc_t;

  typedef struct packed {
    logic        done;
    logic [9:0]  arf;
    logic [11:0] prf;
    logic [1:0]  mv;
    logic [1:0]  sf;
  } wk_t;

  rc_t rc_q[$];
  wk_t wk_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Reference model of the ROB shadow.
  logic [4:0] m_arf [8];
  logic [5:0] m_prf [8];
  logic       m_dst [8];
  logic       m_st  [8];
  int m_head = 0, m_tail = 0, m_occ = 0, m_wp = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if ((recycle_valid | store_commit_valid) != 2'b00) begin
        if (rc_q.size() == 0) check_eq("recycle_unexpected", 32'({recycle_valid, store_commit_valid}), 32'd0);
        else begin
          rc_t e;
          e = rc_q.pop_front();
          check_eq("recycle_valid", 32'(recycle_valid), 32'(e.rv));
          check_eq("store_commit_valid", 32'(store_commit_valid), 32'(e.sv));
          check_eq("recycle_prf", 32'(recycle_prf & e.mask), 32'(e.prf));
        end
      end
      if (rcv_busy) begin
        if (wk_q.size() == 0) check_eq("walk_unexpected", 32'(rcv_busy), 32'd0);
        else begin
          wk_t w;
          w = wk_q.pop_front();
          check_eq("rcv_done", 32'(rcv_done), 32'(w.done));
          check_eq("rcv_arf", 32'(rcv_arf), 32'(w.arf));
          check_eq("rcv_old_prf", 32'(rcv_old_prf), 32'(w.prf));
          check_eq("rcv_map_valid", 32'(rcv_map_valid), 32'(w.mv));
          check_eq("rcv_store_flush", 32'(rcv_store_flush), 32'(w.sf));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = '0; commit_valid = '0; flush_valid = 1'b0; flush_all = 1'b0;
    rc_q.delete();
    wk_q.delete();
    m_head = 0; m_tail = 0; m_occ = 0; m_wp = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic alloc(input logic [1:0] v, input logic [9:0] arf, input logic [11:0] prf,
                       input logic [1:0] dst, input logic [1:0] st);
    logic exp_ready;
    exp_ready = (8 - m_occ) >= 2;
    alloc_valid = v; alloc_arf = arf; alloc_old_prf = prf; alloc_has_dst = dst; alloc_is_store = st;
    #1;
    check_eq("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
    check_eq("alloc_tag", 32'(alloc_tag), 32'(m_tail));
    if (exp_ready) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          m_arf[(m_tail + i) % 8] = arf[i*5 +: 5];
          m_prf[(m_tail + i) % 8] = prf[i*6 +: 6];
          m_dst[(m_tail + i) % 8] = dst[i];
          m_st[(m_tail + i) % 8]  = st[i];
        end
      end
      for (int i = 0; i < 2; i++) if (v[i]) begin m_tail = (m_tail + 1) % 8; m_occ++; end
    end
    tick();
    alloc_valid = '0;
    check_eq("occupancy_alloc", 32'(occupancy), 32'(m_occ));
  endtask

  task automatic commit(input logic [1:0] cv);
    rc_t e;
    e = '0;
    for (int i = 0; i < 2; i++) begin
      if (cv[i]) begin
        e.rv[i] = m_dst[(m_head + i) % 8];
        e.sv[i] = m_st[(m_head + i) % 8];
        if (m_dst[(m_head + i) % 8]) begin
          e.prf[i*6 +: 6]  = m_prf[(m_head + i) % 8];
          e.mask[i*6 +: 6] = 6'h3f;
        end
      end
    end
    if ((e.rv | e.sv) != 2'b00) rc_q.push_back(e);
    for (int i = 0; i < 2; i++) if (cv[i]) begin m_head = (m_head + 1) % 8; m_occ--; end
    commit_valid = cv;
    tick();
    commit_valid = '0;
    check_eq("occupancy_commit", 32'(occupancy), 32'(m_occ));
  endtask

  // Push the lane records a walk of rem entries from wp is expected to produce.
  task automatic gen_walk(input int wp, input int rem);
    wk_t w;
    int  n;
    while (rem > 0) begin
      n = (rem < 2) ? rem : 2;
      w = '0;
      for (int j = 0; j < n; j++) begin
        w.arf[j*5 +: 5] = m_arf[(wp - j + 8) % 8];
        w.prf[j*6 +: 6] = m_prf[(wp - j + 8) % 8];
        w.mv[j]         = m_dst[(wp - j + 8) % 8];
        w.sf[j]         = m_st[(wp - j + 8) % 8];
      end
      wk_q.push_back(w);
      wp = (wp - n + 8) % 8;
      m_tail = (m_tail - n + 8) % 8;
      m_occ -= n;
      rem -= n;
    end
    m_wp = wp;
  endtask

  task automatic push_done();
    wk_t w;
    w = '0;
    w.done = 1'b1;
    wk_q.push_back(w);
  endtask

  task automatic flush(input int tag, input logic all, input logic with_done);
    int rem;
    rem = all ? m_occ : ((m_tail - tag - 1 + 16) % 8);
    gen_walk((m_tail + 7) % 8, rem);
    if (with_done) push_done();
    flush_valid = ~all; flush_all = all; flush_tag = 3'(tag);
    tick();
    flush_valid = 1'b0; flush_all = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (rcv_busy && k < 20) begin tick(); k++; end
    check_eq("walk_timeout", 32'(rcv_busy), 32'd0);
    check_eq("walk_q_drained", 32'(wk_q.size()), 32'd0);
    check_eq("occupancy_walk", 32'(occupancy), 32'(m_occ));
    check_eq("tail_walk", 32'(alloc_tag), 32'(m_tail));
  endtask

  task automatic fill(input int n);
    for (int k = 0; k < n; k += 2) begin
      alloc((n - k >= 2) ? 2'b11 : 2'b01,
            {5'(k + 2), 5'(k + 1)}, {6'(k + 21), 6'(k + 20)},
            {1'(k % 3 != 0), 1'b1}, {1'b0, 1'(k % 4 == 2)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    do_reset();
    check_eq("reset_alloc_ready", 32'(alloc_ready), 32'd1);
    check_eq("reset_occupancy", 32'(occupancy), 32'd0);
    check_eq("reset_alloc_tag", 32'(alloc_tag), 32'd0);
    check_eq("reset_recycle", 32'({recycle_valid, store_commit_valid}), 32'd0);
    check_eq("reset_busy", 32'({rcv_busy, rcv_done}), 32'd0);

    // Basic allocate / commit.
    alloc(2'b11, {5'd4, 5'd3}, {6'd11, 6'd10}, 2'b11, 2'b00);
    commit(2'b11);

    // Fill to occupancy 7, drop an alloc, then free space.
    alloc(2'b11, {5'd6, 5'd5}, {6'd13, 6'd12}, 2'b01, 2'b10);
    alloc(2'b11, {5'd8, 5'd7}, {6'd15, 6'd14}, 2'b11, 2'b00);
    alloc(2'b11, {5'd10, 5'd9}, {6'd17, 6'd16}, 2'b10, 2'b01);
    alloc(2'b01, {5'd0, 5'd11}, {6'd0, 6'd18}, 2'b01, 2'b00);
    alloc(2'b11, {5'd30, 5'd31}, {6'd60, 6'd61}, 2'b11, 2'b11);
    commit(2'b11);
    alloc(2'b00, '0, '0, '0, '0);
    commit(2'b11);
    commit(2'b01);

    // Branch walk of five entries from a 7-entry window.
    do_reset();
    fill(7);
    flush(1, 1'b0, 1'b1);
    wait_idle();

    // Store without destination and destination without store.
    do_reset();
    alloc(2'b11, {5'd2, 5'd1}, {6'd31, 6'd30}, 2'b11, 2'b00);
    alloc(2'b11, {5'd4, 5'd3}, {6'd33, 6'd32}, 2'b11, 2'b00);
    alloc(2'b11, {5'd6, 5'd5}, {6'd35, 6'd34}, 2'b10, 2'b01);
    flush(3, 1'b0, 1'b1);
    wait_idle();

    // Retarget to an older branch during the walk.
    do_reset();
    fill(7);
    flush(5, 1'b0, 1'b0);
    gen_walk(m_wp, ((m_wp + 1 - 2 + 8) % 8) - 1);
    push_done();
    flush_valid = 1'b1; flush_tag = 3'd2;
    tick();
    flush_valid = 1'b0;
    wait_idle();
    commit(2'b11);

    // Full flush over a wrapped window with commits held high.
    do_reset();
    fill(6);
    commit(2'b11);
    commit(2'b11);
    commit(2'b11);
    alloc(2'b11, {5'd12, 5'd11}, {6'd41, 6'd40}, 2'b11, 2'b01);
    alloc(2'b11, {5'd14, 5'd13}, {6'd43, 6'd42}, 2'b01, 2'b10);
    commit_valid = 2'b11;
    flush(0, 1'b1, 1'b1);
    commit_valid = 2'b11;
    wait_idle();
    commit_valid = 2'b00;
    check_eq("flush_all_head_eq_tail", 32'(alloc_tag), 32'(m_head));

    // Reset in the middle of a walk: no done pulse afterwards.
    do_reset();
    fill(7);
    flush(0, 1'b0, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    wk_q.delete();
    m_head = 0; m_tail = 0; m_occ = 0;
    check_eq("abort_busy", 32'({rcv_busy, rcv_done}), 32'd0);
    check_eq("abort_occupancy", 32'(occupancy), 32'd0);
    check_eq("abort_tag", 32'(alloc_tag), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    check_eq("abort_ready", 32'(alloc_ready), 32'd1);

    repeat (3) tick();
    check_eq("rc_q_left", 32'(rc_q.size()), 32'd0);
    check_eq("wk_q_left", 32'(wk_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
